seq_processor: RTL and testbench

SEQ_PROCESSOR -- requirements
Module: seq_processor

---
 rtl/seq_processor.sv | 174 +++++++++++++++++
 tb/tb_seq_processor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_processor.sv
// seq_processor: multi-cycle register processor (IDLE -> READ -> EXEC -> WRITE per instruction).
// Define SEQ_PROCESSOR_SHIFT_EN to build in the SLL/SRL/SRA shifter; otherwise those opcodes raise illegal.
module seq_processor #(
    parameter int DW = 16,
    parameter int AW = 6,
    localparam int SW = $clog2(DW),
    localparam int IW = 3 + 3*AW + DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] inst,
    input  logic          inst_valid,
    output logic          inst_ready,
    output logic [AW-1:0] out1,
    output logic [AW-1:0] out2,
    output logic [DW-1:0] out3,
    output logic [DW-1:0] out4,
    output logic [3:0]    out_en,
    output logic [1:0]    flags,
    output logic          done,
    output logic          illegal
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        EXEC   = 3'd2,
        WRITE  = 3'd3,
        HALTED = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_LDI  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_SLL  = 3'b011,
        OP_SRL  = 3'b100,
        OP_SRA  = 3'b101,
        OP_DISP = 3'b110,
        OP_HALT = 3'b111
    } op_t;

    state_t        state;
    logic [IW-1:0] inst_q;
    logic [DW-1:0] regs [2**AW];
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] result;
    logic          res_carry;
    logic          res_ovf;

    op_t           op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] imm;

    assign op  = op_t'(inst_q[IW-1 -: 3]);
    assign rd  = inst_q[IW-4 -: AW];
    assign rs1 = inst_q[IW-4-AW -: AW];
    assign rs2 = inst_q[IW-4-2*AW -: AW];
    assign imm = inst_q[DW-1:0];

    // SUB is a + ~b + 1, so its carry-out reads as "no borrow".
    logic [DW:0] sum;
    logic [DW:0] diff;
    logic        add_ovf;
    logic        sub_ovf;

    assign sum     = {1'b0, op_a} + {1'b0, op_b};
    assign diff    = {1'b0, op_a} + {1'b0, ~op_b} + {{DW{1'b0}}, 1'b1};
    assign add_ovf = (op_a[DW-1] == op_b[DW-1]) && (sum[DW-1] != op_a[DW-1]);
    assign sub_ovf = (op_a[DW-1] != op_b[DW-1]) && (diff[DW-1] != op_a[DW-1]);

`ifdef SEQ_PROCESSOR_SHIFT_EN
    logic [SW-1:0] shamt;
    assign shamt = imm[SW-1:0];
`endif

    assign inst_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            inst_q    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out4      <= '0;
            out_en    <= '0;
            flags     <= '0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            for (int i = 0; i < 2**AW; i++) begin
                regs[i] <= '0;
            end
        end else begin
            out_en  <= '0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_valid) begin
                        inst_q <= inst;
                        state  <= READ;
                    end
                end
                READ: begin
                    op_a  <= regs[rs1];
                    op_b  <= regs[rs2];
                    state <= EXEC;
                end
                EXEC: begin
                    result    <= '0;
                    res_carry <= 1'b0;
                    res_ovf   <= 1'b0;
                    case (op)
                        OP_LDI: result <= imm;
                        OP_ADD: begin
                            result    <= sum[DW-1:0];
                            res_carry <= sum[DW];
                            res_ovf   <= add_ovf;
                        end
                        OP_SUB: begin
                            result    <= diff[DW-1:0];
                            res_carry <= diff[DW];
                            res_ovf   <= sub_ovf;
                        end
`ifdef SEQ_PROCESSOR_SHIFT_EN
                        OP_SLL: result <= op_a << shamt;
                        OP_SRL: result <= op_a >> shamt;
                        OP_SRA: result <= $unsigned($signed(op_a) >>> shamt);
`endif
                        default: result <= '0;
                    endcase
                    state <= WRITE;
                end
                WRITE: begin
                    state <= IDLE;
                    case (op)
                        OP_LDI, OP_ADD, OP_SUB: regs[rd] <= result;
`ifdef SEQ_PROCESSOR_SHIFT_EN
                        OP_SLL, OP_SRL, OP_SRA: regs[rd] <= result;
`else
                        OP_SLL, OP_SRL, OP_SRA: illegal <= 1'b1;
`endif
                        OP_DISP: begin
                            out1   <= rs1;
                            out2   <= rs2;
                            out3   <= op_a;
                            out4   <= op_b;
                            out_en <= 4'b1111;
                        end
                        OP_HALT: begin
                            state <= HALTED;
                            done  <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                    if (op == OP_ADD || op == OP_SUB) begin
                        flags <= {res_carry, res_ovf};
                    end
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_processor.sv
// Directed self-checking bench for seq_processor; register contents are observed through DISP.
module tb_seq_processor;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int IW = 3 + 3*AW + DW;

    localparam logic [2:0] LDI  = 3'b000;
    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] SUB  = 3'b010;
    localparam logic [2:0] SLL  = 3'b011;
    localparam logic [2:0] SRL  = 3'b100;
    localparam logic [2:0] SRA  = 3'b101;
    localparam logic [2:0] DISP = 3'b110;
    localparam logic [2:0] HALT = 3'b111;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] inst;
    logic          inst_valid;
    logic          inst_ready;
    logic [AW-1:0] out1;
    logic [AW-1:0] out2;
    logic [DW-1:0] out3;
    logic [DW-1:0] out4;
    logic [3:0]    out_en;
    logic [1:0]    flags;
    logic          done;
    logic          illegal;

    int check_count = 0;
    int pass_count  = 0;
    int ready_cnt;
    int first_idx;
    int second_idx;
    logic seen_ready;

    seq_processor #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out4       (out4),
        .out_en     (out_en),
        .flags      (flags),
        .done       (done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Bounded wait for IDLE, sampled on the falling edge.
    task automatic waitReady();
        int n = 0;
        @(negedge clk);
        while (!inst_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready", {31'd0, inst_ready}, 32'd1);
    endtask

    // Issues one instruction, scrambles inst after acceptance, returns #1 after the WRITE edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [5:0] rd, input logic [5:0] rs1,
                                 input logic [5:0] rs2, input logic [15:0] imm);
        waitReady();
        inst       = {op, rd, rs1, rs2, imm};
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst       = '1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        inst       = '0;
        inst_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_en", {28'd0, out_en}, 32'd0);
        checkOutput("rst_flags", {30'd0, flags}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_out3", {16'd0, out3}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", {31'd0, inst_ready}, 32'd1);

        applyStimulus(LDI, 6'd3, 6'd0, 6'd0, 16'h1234);
        applyStimulus(DISP, 6'd0, 6'd3, 6'd0, 16'h0000);
        checkOutput("disp_out1", {26'd0, out1}, 32'd3);
        checkOutput("disp_out2", {26'd0, out2}, 32'd0);
        checkOutput("disp_out3", {16'd0, out3}, 32'h1234);
        checkOutput("disp_out4", {16'd0, out4}, 32'h0000);
        checkOutput("disp_out_en", {28'd0, out_en}, 32'hF);
        @(posedge clk);
        #1;
        checkOutput("disp_out_en_pulse", {28'd0, out_en}, 32'h0);
        checkOutput("disp_out3_hold", {16'd0, out3}, 32'h1234);

        applyStimulus(LDI, 6'd1, 6'd0, 6'd0, 16'h7FFF);
        applyStimulus(LDI, 6'd2, 6'd0, 6'd0, 16'h0001);
        applyStimulus(ADD, 6'd4, 6'd1, 6'd2, 16'h0000);
        checkOutput("add_ovf_flags", {30'd0, flags}, 32'b01);
        applyStimulus(DISP, 6'd0, 6'd4, 6'd1, 16'h0000);
        checkOutput("add_r4", {16'd0, out3}, 32'h8000);
        checkOutput("add_r1", {16'd0, out4}, 32'h7FFF);
        checkOutput("disp_keeps_flags", {30'd0, flags}, 32'b01);

        applyStimulus(LDI, 6'd1, 6'd0, 6'd0, 16'hFFFF);
        applyStimulus(SUB, 6'd1, 6'd1, 6'd1, 16'h0000);
        checkOutput("sub_self_flags", {30'd0, flags}, 32'b10);
        applyStimulus(SUB, 6'd7, 6'd0, 6'd2, 16'h0000);
        checkOutput("sub_borrow_flags", {30'd0, flags}, 32'b00);
        applyStimulus(LDI, 6'd8, 6'd0, 6'd0, 16'h8000);
        applyStimulus(ADD, 6'd9, 6'd8, 6'd8, 16'h0000);
        checkOutput("add_carry_ovf_flags", {30'd0, flags}, 32'b11);
        applyStimulus(DISP, 6'd0, 6'd1, 6'd2, 16'h0000);
        checkOutput("sub_self_r1", {16'd0, out3}, 32'h0000);
        checkOutput("r2_value", {16'd0, out4}, 32'h0001);
        applyStimulus(DISP, 6'd0, 6'd7, 6'd9, 16'h0000);
        checkOutput("sub_borrow_r7", {16'd0, out3}, 32'hFFFF);
        checkOutput("add_wrap_r9", {16'd0, out4}, 32'h0000);

        applyStimulus(LDI, 6'd13, 6'd0, 6'd0, 16'h0005);
        applyStimulus(ADD, 6'd13, 6'd13, 6'd13, 16'h0000);
        checkOutput("add_small_flags", {30'd0, flags}, 32'b00);
        applyStimulus(DISP, 6'd0, 6'd13, 6'd13, 16'h0000);
        checkOutput("rd_eq_rs_r13", {16'd0, out3}, 32'h000A);

        applyStimulus(LDI, 6'd5, 6'd0, 6'd0, 16'h8001);
        applyStimulus(SRA, 6'd6, 6'd5, 6'd0, 16'h0001);
`ifdef SEQ_PROCESSOR_SHIFT_EN
        checkOutput("sra_no_illegal", {31'd0, illegal}, 32'd0);
        applyStimulus(SLL, 6'd10, 6'd5, 6'd0, 16'h0004);
        applyStimulus(SRL, 6'd11, 6'd5, 6'd0, 16'h000F);
        applyStimulus(SRL, 6'd12, 6'd5, 6'd0, 16'h0010);
        applyStimulus(DISP, 6'd0, 6'd6, 6'd10, 16'h0000);
        checkOutput("sra_r6", {16'd0, out3}, 32'hC000);
        checkOutput("sll_r10", {16'd0, out4}, 32'h0010);
        applyStimulus(DISP, 6'd0, 6'd11, 6'd12, 16'h0000);
        checkOutput("srl_r11", {16'd0, out3}, 32'h0001);
        checkOutput("shift_zero_r12", {16'd0, out4}, 32'h8001);
`else
        checkOutput("sra_illegal", {31'd0, illegal}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("sra_illegal_pulse", {31'd0, illegal}, 32'd0);
        applyStimulus(DISP, 6'd0, 6'd6, 6'd5, 16'h0000);
        checkOutput("sra_r6_unchanged", {16'd0, out3}, 32'h0000);
        checkOutput("r5_value", {16'd0, out4}, 32'h8001);
`endif
        checkOutput("shift_keeps_flags", {30'd0, flags}, 32'b00);

        waitReady();
        inst       = {LDI, 6'd14, 6'd0, 6'd0, 16'h0BEE};
        inst_valid = 1'b1;
        ready_cnt  = 0;
        first_idx  = -1;
        second_idx = -1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (inst_ready) begin
                ready_cnt++;
                if (first_idx < 0) first_idx = i;
                else if (second_idx < 0) second_idx = i;
            end
        end
        inst_valid = 1'b0;
        checkOutput("thru_ready_count", ready_cnt, 32'd4);
        checkOutput("thru_period", second_idx - first_idx, 32'd4);
        applyStimulus(DISP, 6'd0, 6'd14, 6'd0, 16'h0000);
        checkOutput("thru_r14", {16'd0, out3}, 32'h0BEE);

        applyStimulus(LDI, 6'd15, 6'd0, 6'd0, 16'h00AA);
        waitReady();
        inst       = {ADD, 6'd15, 6'd15, 6'd15, 16'h0000};
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready", {31'd0, inst_ready}, 32'd1);
        checkOutput("midrst_out3", {16'd0, out3}, 32'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(DISP, 6'd0, 6'd15, 6'd4, 16'h0000);
        checkOutput("midrst_r15", {16'd0, out3}, 32'h0000);
        checkOutput("midrst_r4", {16'd0, out4}, 32'h0000);
        checkOutput("midrst_flags", {30'd0, flags}, 32'b00);

        checkOutput("done_before_halt", {31'd0, done}, 32'd0);
        waitReady();
        inst       = {HALT, 6'd0, 6'd0, 6'd0, 16'h0000};
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("done_early", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("done", {31'd0, done}, 32'd1);
        checkOutput("halt_ready", {31'd0, inst_ready}, 32'd0);
        inst       = {LDI, 6'd1, 6'd0, 6'd0, 16'h5555};
        inst_valid = 1'b1;
        seen_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (inst_ready) seen_ready = 1'b1;
        end
        inst_valid = 1'b0;
        checkOutput("halt_ready_hold", {31'd0, seen_ready}, 32'd0);
        checkOutput("halt_done_hold", {31'd0, done}, 32'd1);
        checkOutput("halt_no_write", {16'd0, dut.regs[1]}, 32'h0000);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
